// File: rtl/uart_port_router.sv
// Routes the board UART pair to one of NCH internal endpoints. The selection comes from debounced
// board pins and is committed only while both affected lines are idle at mark.
module uart_port_router #(
  parameter int             NCH             = 2,
  parameter int             SEL_W           = 1,
  parameter int             DEFAULT_SEL     = 0,
  parameter logic [NCH-1:0] MONITOR_MASK    = 2'b01,
  parameter int             DEBOUNCE_CYCLES = 65536,
  parameter int             IDLE_CYCLES     = 2604
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             ext_rx,
  output logic             ext_tx,
  input  logic [NCH-1:0]   ch_tx,
  output logic [NCH-1:0]   ch_rx,
  output logic [SEL_W-1:0] active_sel,
  output logic             switching
);

  localparam int               DEB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int               IDLE_W    = $clog2(IDLE_CYCLES) + 1;
  localparam int               SEL_W1    = SEL_W + 1;
  localparam logic [SEL_W-1:0] SEL_DEF   = SEL_W'(DEFAULT_SEL);
  localparam logic [SEL_W:0]   SEL_LIMIT = SEL_W1'(NCH);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = {IDLE_W{1'b1}};

  typedef enum logic [0:0] {
    ST_ACTIVE    = 1'b0,
    ST_WAIT_IDLE = 1'b1
  } state_t;

  logic             rx_meta_r;
  logic             rx_s_r;
  logic [SEL_W-1:0] sel_meta_r;
  logic [SEL_W-1:0] sel_s_r;
  logic [SEL_W-1:0] cand_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [SEL_W-1:0] deb_sel_r;
  logic [SEL_W-1:0] pending_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  state_t           state_r;

  logic             active_tx_s;
  logic             lines_idle_s;
  logic             cand_legal_s;
  logic [NCH-1:0]   rx_route_s;

  // Two-flop synchronisers for the asynchronous RX pin and the selection pins
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r  <= 1'b1;
      rx_s_r     <= 1'b1;
      sel_meta_r <= SEL_DEF;
      sel_s_r    <= SEL_DEF;
    end else begin
      rx_meta_r  <= ext_rx;
      rx_s_r     <= rx_meta_r;
      sel_meta_r <= sel_req;
      sel_s_r    <= sel_meta_r;
    end
  end

  // Line status and per-channel RX routing, derived from the committed selection
  always_comb begin
    active_tx_s  = ch_tx[active_sel];
    lines_idle_s = rx_s_r & active_tx_s;
    cand_legal_s = ({1'b0, cand_r} < SEL_LIMIT);
    rx_route_s   = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((active_sel == SEL_W'(i)) || MONITOR_MASK[i]) begin
        rx_route_s[i] = 1'b1;
      end else begin
        rx_route_s[i] = 1'b0;
      end
    end
  end

  // Debounce: a code must be stable for DEBOUNCE_CYCLES and be a real channel to be accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_r    <= SEL_DEF;
      deb_cnt_r <= '0;
      deb_sel_r <= SEL_DEF;
    end else if (sel_s_r != cand_r) begin
      cand_r    <= sel_s_r;
      deb_cnt_r <= '0;
    end else begin
      if (deb_cnt_r != DEB_LAST) begin
        deb_cnt_r <= deb_cnt_r + 1'b1;
      end
      if ((deb_cnt_r == DEB_LAST) && cand_legal_s) begin
        deb_sel_r <= cand_r;
      end
    end
  end

  // Switch controller: waits for both lines to idle before committing a new channel
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_ACTIVE;
      active_sel <= SEL_DEF;
      switching  <= 1'b0;
      pending_r  <= SEL_DEF;
      idle_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_ACTIVE: begin
          if (deb_sel_r != active_sel) begin
            pending_r  <= deb_sel_r;
            idle_cnt_r <= '0;
            state_r    <= ST_WAIT_IDLE;
            switching  <= 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (deb_sel_r == active_sel) begin
            state_r    <= ST_ACTIVE;
            switching  <= 1'b0;
            idle_cnt_r <= '0;
          end else if (deb_sel_r != pending_r) begin
            pending_r  <= deb_sel_r;
            idle_cnt_r <= '0;
          end else if (!lines_idle_s) begin
            idle_cnt_r <= '0;
          end else if (idle_cnt_r == IDLE_LAST) begin
            active_sel <= pending_r;
            state_r    <= ST_ACTIVE;
            switching  <= 1'b0;
            idle_cnt_r <= '0;
          end else if (idle_cnt_r != IDLE_SAT) begin
            idle_cnt_r <= idle_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r    <= ST_ACTIVE;
          switching  <= 1'b0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered datapath; deselected non-monitor endpoints are held at mark
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_tx <= 1'b1;
      ch_rx  <= {NCH{1'b1}};
    end else begin
      ext_tx <= active_tx_s;
      ch_rx  <= (rx_route_s & {NCH{rx_s_r}}) | ~rx_route_s;
    end
  end

endmodule
